// File: rtl/stg_ma_if.sv
// stg_ma_if: data-memory transaction bus between the MA stage (master) and data memory (slave).
// Latency: none, wires only.
// Backpressure: the master holds ow_mem_req until the slave returns a 1-cycle iw_mem_ack.
interface stg_ma_if #(
    parameter int AW = 48,
    parameter int DW = 24
);
    logic          ow_mem_req;
    logic          ow_mem_we;
    logic [AW-1:0] ow_mem_addr;
    logic [DW-1:0] ow_mem_wdata;
    logic          iw_mem_ack;
    logic [DW-1:0] iw_mem_rdata;

    modport master (
        output ow_mem_req, ow_mem_we, ow_mem_addr, ow_mem_wdata,
        input  iw_mem_ack, iw_mem_rdata
    );

    modport slave (
        input  ow_mem_req, ow_mem_we, ow_mem_addr, ow_mem_wdata,
        output iw_mem_ack, iw_mem_rdata
    );
endinterface

// File: rtl/stg_ma.sv
// stg_ma: memory-access stage; non-memory ops pass through, LD/ST ops run one req/ack bus transaction.
// Latency: 1 cycle for non-memory ops; 2+ cycles for memory ops (capture edge, then ack edge).
// Backpressure: ow_stall holds upstream while a transaction is open; iw_stall freezes IDLE and parks acked data in HOLD.
module stg_ma #(
    parameter int MEM_TIMEOUT = 255,
    parameter int OPC_W       = 6,
    parameter int GP_W        = 4,
    parameter int SR_W        = 3,
    parameter int AR_W        = 2
) (
    input  logic             iw_clk,
    input  logic             iw_rst,

    input  logic [47:0]      iw_pc,
    input  logic [23:0]      iw_instr,
    input  logic [OPC_W-1:0] iw_opc,
    input  logic [GP_W-1:0]  iw_tgt_gp,
    input  logic             iw_tgt_gp_we,
    input  logic [SR_W-1:0]  iw_tgt_sr,
    input  logic             iw_tgt_sr_we,
    input  logic [AR_W-1:0]  iw_tgt_ar,
    input  logic             iw_tgt_ar_we,
    input  logic [47:0]      iw_addr,
    input  logic [23:0]      iw_result,
    input  logic [47:0]      iw_ar_result,
    input  logic [47:0]      iw_sr_result,

    output logic [47:0]      ow_pc,
    output logic [23:0]      ow_instr,
    output logic [OPC_W-1:0] ow_opc,
    output logic [GP_W-1:0]  ow_tgt_gp,
    output logic             ow_tgt_gp_we,
    output logic [SR_W-1:0]  ow_tgt_sr,
    output logic             ow_tgt_sr_we,
    output logic [AR_W-1:0]  ow_tgt_ar,
    output logic             ow_tgt_ar_we,
    output logic [23:0]      ow_result,
    output logic [47:0]      ow_ar_result,
    output logic [47:0]      ow_sr_result,

    stg_ma_if.master         mem,
    output logic             ow_mem_fault,

    input  logic             iw_flush,
    input  logic             iw_stall,
    output logic             ow_stall
);

    // Opcode classes live in the top three opcode bits: 3'b010 = loads, 3'b011 = stores.
    localparam logic [2:0] OPC_CLS_LD = 3'b010;
    localparam logic [2:0] OPC_CLS_ST = 3'b011;

    localparam int             CNT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD
    } state_t;

    // Everything that travels down the pipe with an instruction.
    typedef struct packed {
        logic [47:0]      pc;
        logic [23:0]      instr;
        logic [OPC_W-1:0] opc;
        logic [GP_W-1:0]  tgt_gp;
        logic             tgt_gp_we;
        logic [SR_W-1:0]  tgt_sr;
        logic             tgt_sr_we;
        logic [AR_W-1:0]  tgt_ar;
        logic             tgt_ar_we;
        logic [23:0]      result;
        logic [47:0]      ar_result;
        logic [47:0]      sr_result;
    } op_t;

    // A bubble is the op with every register-file write suppressed.
    function automatic op_t bubble_op(input op_t o);
        op_t r;
        r           = o;
        r.tgt_gp_we = 1'b0;
        r.tgt_sr_we = 1'b0;
        r.tgt_ar_we = 1'b0;
        return r;
    endfunction

    // Retiring memory op: WB data replaced by the transaction data, killed ops become bubbles.
    function automatic op_t retire_op(input op_t o, input logic [23:0] dat, input logic kill);
        op_t r;
        r        = o;
        r.result = dat;
        if (kill) begin
            r = bubble_op(r);
        end
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             kill_q, kill_d;
    op_t              out_q, out_d;
    op_t              cap_q, cap_d;
    logic [47:0]      addr_q, addr_d;
    logic             st_q, st_d;
    logic             req_q, req_d;
    logic             fault_q, fault_d;
    logic [23:0]      buf_q, buf_d;

    op_t              in_op;
    logic             in_is_ld;
    logic             in_is_st;
    logic [CNT_W-1:0] cnt_inc;
    logic             kill_now;
    logic [23:0]      xfer_dat;

    assign in_op = '{
        pc:        iw_pc,
        instr:     iw_instr,
        opc:       iw_opc,
        tgt_gp:    iw_tgt_gp,
        tgt_gp_we: iw_tgt_gp_we,
        tgt_sr:    iw_tgt_sr,
        tgt_sr_we: iw_tgt_sr_we,
        tgt_ar:    iw_tgt_ar,
        tgt_ar_we: iw_tgt_ar_we,
        result:    iw_result,
        ar_result: iw_ar_result,
        sr_result: iw_sr_result
    };

    assign in_is_ld = (iw_opc[OPC_W-1 -: 3] == OPC_CLS_LD);
    assign in_is_st = (iw_opc[OPC_W-1 -: 3] == OPC_CLS_ST);

    // Saturating wait counter; it is cleared on entry to WAIT so it never starts saturated there.
    assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    // A flush arriving in the retire cycle itself must still kill the op.
    assign kill_now = kill_q | iw_flush;
    // Stores write back their own captured result, loads write back the bus data.
    assign xfer_dat = st_q ? cap_q.result : mem.iw_mem_rdata;

    // State register.
    always_ff @(posedge iw_clk or negedge iw_rst) begin
        if (!iw_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, transaction control and output register update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kill_d  = kill_q;
        out_d   = out_q;
        cap_d   = cap_q;
        addr_d  = addr_q;
        st_d    = st_q;
        req_d   = req_q;
        fault_d = 1'b0;
        buf_d   = buf_q;

        case (state_q)
            S_IDLE: begin
                if (!iw_stall) begin
                    if (iw_flush) begin
                        out_d = bubble_op(in_op);
                    end else if (in_is_ld || in_is_st) begin
                        cap_d   = in_op;
                        addr_d  = iw_addr;
                        st_d    = in_is_st;
                        req_d   = 1'b1;
                        cnt_d   = '0;
                        kill_d  = 1'b0;
                        out_d   = bubble_op(in_op);
                        state_d = S_WAIT;
                    end else begin
                        out_d = in_op;
                    end
                end
            end

            S_WAIT: begin
                cnt_d = cnt_inc;
                if (iw_flush) begin
                    kill_d = 1'b1;
                end
                // Ack is checked first so an ack on the timeout cycle still completes the op.
                if (mem.iw_mem_ack) begin
                    req_d = 1'b0;
                    if (iw_stall) begin
                        buf_d   = xfer_dat;
                        state_d = S_HOLD;
                    end else begin
                        out_d   = retire_op(cap_q, xfer_dat, kill_now);
                        kill_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end else if (cnt_inc == CNT_MAX) begin
                    req_d   = 1'b0;
                    fault_d = 1'b1;
                    out_d   = bubble_op(cap_q);
                    kill_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end

            S_HOLD: begin
                if (iw_flush) begin
                    kill_d = 1'b1;
                end
                if (!iw_stall) begin
                    out_d   = retire_op(cap_q, buf_q, kill_now);
                    kill_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // Datapath and control registers; reset drops any transaction in flight.
    always_ff @(posedge iw_clk or negedge iw_rst) begin
        if (!iw_rst) begin
            cnt_q   <= '0;
            kill_q  <= 1'b0;
            out_q   <= '0;
            cap_q   <= '0;
            addr_q  <= '0;
            st_q    <= 1'b0;
            req_q   <= 1'b0;
            fault_q <= 1'b0;
            buf_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            kill_q  <= kill_d;
            out_q   <= out_d;
            cap_q   <= cap_d;
            addr_q  <= addr_d;
            st_q    <= st_d;
            req_q   <= req_d;
            fault_q <= fault_d;
            buf_q   <= buf_d;
        end
    end

    assign ow_pc        = out_q.pc;
    assign ow_instr     = out_q.instr;
    assign ow_opc       = out_q.opc;
    assign ow_tgt_gp    = out_q.tgt_gp;
    assign ow_tgt_gp_we = out_q.tgt_gp_we;
    assign ow_tgt_sr    = out_q.tgt_sr;
    assign ow_tgt_sr_we = out_q.tgt_sr_we;
    assign ow_tgt_ar    = out_q.tgt_ar;
    assign ow_tgt_ar_we = out_q.tgt_ar_we;
    assign ow_result    = out_q.result;
    assign ow_ar_result = out_q.ar_result;
    assign ow_sr_result = out_q.sr_result;

    // Bus fields come straight from capture registers, so they cannot move while req is up.
    assign mem.ow_mem_req   = req_q;
    assign mem.ow_mem_we    = st_q;
    assign mem.ow_mem_addr  = addr_q;
    assign mem.ow_mem_wdata = cap_q.result;
    assign ow_mem_fault     = fault_q;

    assign ow_stall = (state_q != S_IDLE) | iw_stall;

endmodule

// File: tb/tb_stg_ma.sv
module tb_stg_ma;
    localparam int TMO = 4;
    localparam logic [2:0] CLS_ALU = 3'b000;
    localparam logic [2:0] CLS_LD  = 3'b010;
    localparam logic [2:0] CLS_ST  = 3'b011;

    logic        clk = 1'b0;
    logic        iw_rst;
    logic [47:0] iw_pc, ow_pc;
    logic [23:0] iw_instr, ow_instr;
    logic [5:0]  iw_opc, ow_opc;
    logic [3:0]  iw_tgt_gp, ow_tgt_gp;
    logic        iw_tgt_gp_we, ow_tgt_gp_we;
    logic [2:0]  iw_tgt_sr, ow_tgt_sr;
    logic        iw_tgt_sr_we, ow_tgt_sr_we;
    logic [1:0]  iw_tgt_ar, ow_tgt_ar;
    logic        iw_tgt_ar_we, ow_tgt_ar_we;
    logic [47:0] iw_addr;
    logic [23:0] iw_result, ow_result;
    logic [47:0] iw_ar_result, ow_ar_result;
    logic [47:0] iw_sr_result, ow_sr_result;
    logic        ow_mem_fault;
    logic        iw_flush, iw_stall, ow_stall;
    logic [2:0]  we3;

    int total = 0;
    int bad   = 0;

    // Reference view of what the stage outputs currently hold.
    logic [23:0] m_res;
    logic [2:0]  m_we;
    bit          m_res_ok;

    stg_ma_if mem_if ();

    stg_ma #(.MEM_TIMEOUT(TMO)) dut (
        .iw_clk(clk), .iw_rst(iw_rst),
        .iw_pc(iw_pc), .iw_instr(iw_instr), .iw_opc(iw_opc),
        .iw_tgt_gp(iw_tgt_gp), .iw_tgt_gp_we(iw_tgt_gp_we),
        .iw_tgt_sr(iw_tgt_sr), .iw_tgt_sr_we(iw_tgt_sr_we),
        .iw_tgt_ar(iw_tgt_ar), .iw_tgt_ar_we(iw_tgt_ar_we),
        .iw_addr(iw_addr), .iw_result(iw_result),
        .iw_ar_result(iw_ar_result), .iw_sr_result(iw_sr_result),
        .ow_pc(ow_pc), .ow_instr(ow_instr), .ow_opc(ow_opc),
        .ow_tgt_gp(ow_tgt_gp), .ow_tgt_gp_we(ow_tgt_gp_we),
        .ow_tgt_sr(ow_tgt_sr), .ow_tgt_sr_we(ow_tgt_sr_we),
        .ow_tgt_ar(ow_tgt_ar), .ow_tgt_ar_we(ow_tgt_ar_we),
        .ow_result(ow_result), .ow_ar_result(ow_ar_result), .ow_sr_result(ow_sr_result),
        .mem(mem_if.master), .ow_mem_fault(ow_mem_fault),
        .iw_flush(iw_flush), .iw_stall(iw_stall), .ow_stall(ow_stall)
    );

    assign we3 = {ow_tgt_gp_we, ow_tgt_sr_we, ow_tgt_ar_we};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_op(input logic [2:0] cls, input logic [23:0] res,
                            input logic [47:0] adr, input logic [2:0] wes);
        iw_opc       = {cls, 3'($urandom)};
        iw_pc        = {16'($urandom), 32'($urandom)};
        iw_instr     = 24'($urandom);
        iw_tgt_gp    = 4'($urandom);
        iw_tgt_sr    = 3'($urandom);
        iw_tgt_ar    = 2'($urandom);
        {iw_tgt_gp_we, iw_tgt_sr_we, iw_tgt_ar_we} = wes;
        iw_result    = res;
        iw_addr      = adr;
        iw_ar_result = {16'($urandom), 32'($urandom)};
        iw_sr_result = {16'($urandom), 32'($urandom)};
    endtask

    task automatic drive_nop();
        iw_opc = '0; iw_pc = '0; iw_instr = '0;
        iw_tgt_gp = '0; iw_tgt_sr = '0; iw_tgt_ar = '0;
        iw_tgt_gp_we = 1'b0; iw_tgt_sr_we = 1'b0; iw_tgt_ar_we = 1'b0;
        iw_result = '0; iw_addr = '0; iw_ar_result = '0; iw_sr_result = '0;
    endtask

    // Outputs must equal the op still presented on the inputs, with the given WB data and enables.
    task automatic chk_retire(input logic [23:0] res, input logic [2:0] wes);
        chk_eq("ret_res", ow_result, res);
        chk_eq("ret_we", we3, wes);
        chk_eq("ret_pc", ow_pc, iw_pc);
        chk_eq("ret_fields", {ow_instr, ow_opc, ow_tgt_gp, ow_tgt_sr, ow_tgt_ar},
                             {iw_instr, iw_opc, iw_tgt_gp, iw_tgt_sr, iw_tgt_ar});
        chk_eq("ret_ar", ow_ar_result, iw_ar_result);
        chk_eq("ret_sr", ow_sr_result, iw_sr_result);
        chk_eq("ret_stall", ow_stall, 0);
    endtask

    task automatic run_alu(input logic [23:0] res, input logic [2:0] wes,
                           input int stall_n, input bit flush);
        drive_op(CLS_ALU, res, 48'h0, wes);
        iw_flush = flush;
        iw_stall = (stall_n > 0);
        for (int i = 0; i < stall_n; i++) begin
            @(negedge clk);
            chk_eq("idle_hold_we", we3, m_we);
            if (m_res_ok) chk_eq("idle_hold_res", ow_result, m_res);
            chk_eq("idle_hold_stall", ow_stall, 1);
        end
        iw_stall = 1'b0;
        @(negedge clk);
        chk_eq("alu_req", mem_if.ow_mem_req, 0);
        if (flush) begin
            chk_eq("flush_we", we3, 0);
            chk_eq("flush_stall", ow_stall, 0);
            m_we = 3'b000; m_res_ok = 1'b0;
        end else begin
            chk_retire(res, wes);
            m_we = wes; m_res = res; m_res_ok = 1'b1;
        end
        iw_flush = 1'b0;
        drive_nop();
    endtask

    // d: WAIT cycle (1-based) on which ack arrives; d > TMO means no ack before abort.
    task automatic run_mem(input bit st, input logic [47:0] adr, input logic [23:0] res,
                           input logic [23:0] rd, input int d, input bit stall_ack,
                           input int hold_n, input int flush_at);
        logic [2:0] wes;
        int nreq, nfault, unstable, k, ereq;
        bit tmo, kill;
        wes = 3'($urandom) | 3'b100;
        drive_op(st ? CLS_ST : CLS_LD, res, adr, wes);
        iw_stall = 1'b0; iw_flush = 1'b0; mem_if.iw_mem_ack = 1'b0;
        tmo  = (d > TMO);
        ereq = tmo ? TMO : d;
        kill = (flush_at > 0) && (flush_at <= ereq);
        nreq = 0; nfault = 0; unstable = 0; k = 0;
        @(negedge clk);
        while (mem_if.ow_mem_req === 1'b1 && k < 40) begin
            k++;
            nreq++;
            if (mem_if.ow_mem_addr !== adr || mem_if.ow_mem_we !== st ||
                mem_if.ow_mem_wdata !== res || ow_stall !== 1'b1 || we3 !== 3'b000)
                unstable++;
            if (ow_mem_fault === 1'b1) nfault++;
            mem_if.iw_mem_ack   = (k == d);
            mem_if.iw_mem_rdata = (k == d) ? rd : 24'($urandom);
            iw_stall = (k == d) && stall_ack;
            iw_flush = (k == flush_at);
            @(negedge clk);
        end
        if (ow_mem_fault === 1'b1) nfault++;
        mem_if.iw_mem_ack = 1'b0;
        iw_flush = 1'b0;
        chk_eq("req_cycles", nreq, ereq);
        chk_eq("bus_stable", unstable, 0);
        chk_eq("fault_cnt", nfault, tmo);
        if (!tmo && stall_ack) begin
            chk_eq("hold_stall", ow_stall, 1);
            chk_eq("hold_we", we3, 0);
            for (int i = 1; i < hold_n; i++) begin
                mem_if.iw_mem_ack   = 1'b1;
                mem_if.iw_mem_rdata = ~rd;
                @(negedge clk);
                mem_if.iw_mem_ack = 1'b0;
                chk_eq("hold_keep", {ow_stall, mem_if.ow_mem_req, we3}, {1'b1, 1'b0, 3'b000});
            end
            iw_stall = 1'b0;
            @(negedge clk);
        end
        if (tmo) begin
            chk_eq("tmo_we", we3, 0);
            chk_eq("tmo_stall", ow_stall, 0);
            drive_nop();
            @(negedge clk);
            chk_eq("fault_pulse", ow_mem_fault, 0);
            m_we = 3'b000; m_res = 24'h0; m_res_ok = 1'b1;
        end else if (kill) begin
            chk_eq("kill_we", we3, 0);
            chk_eq("kill_stall", ow_stall, 0);
            m_we = 3'b000; m_res_ok = 1'b0;
        end else begin
            chk_retire(st ? res : rd, wes);
            m_we = wes; m_res = st ? res : rd; m_res_ok = 1'b1;
        end
        drive_nop();
    endtask

    initial begin
        int kind, d, fa;
        iw_rst = 1'b0;
        iw_flush = 1'b0;
        iw_stall = 1'b0;
        mem_if.iw_mem_ack = 1'b0;
        mem_if.iw_mem_rdata = '0;
        drive_nop();
        repeat (3) @(negedge clk);
        chk_eq("rst_out", {ow_result, we3, ow_pc[15:0]}, 0);
        chk_eq("rst_bus", {mem_if.ow_mem_req, ow_mem_fault, ow_stall}, 0);
        iw_rst = 1'b1;
        m_we = 3'b000; m_res = 24'h0; m_res_ok = 1'b1;

        // Directed scenarios.
        run_alu(24'h00A5B6, 3'b100, 0, 1'b0);
        run_mem(1'b0, 48'h200, 24'h111111, 24'h00C0DE, 3, 1'b0, 1, 0);
        run_mem(1'b1, 48'h300, 24'h00EF12, 24'h0BAD00, 1, 1'b0, 1, 0);
        run_mem(1'b0, 48'h400, 24'h222222, 24'h333333, 6, 1'b0, 1, 0);
        run_alu(24'h00BEEF, 3'b010, 0, 1'b0);
        run_mem(1'b0, 48'h500, 24'h444444, 24'h00CAFE, TMO, 1'b0, 1, 0);
        run_mem(1'b0, 48'h600, 24'h555555, 24'h00F00D, 2, 1'b1, 2, 0);
        run_mem(1'b0, 48'h700, 24'h666666, 24'h777777, 3, 1'b0, 1, 2);
        run_alu(24'h0ABCDE, 3'b111, 2, 1'b0);
        run_alu(24'h012345, 3'b111, 0, 1'b1);

        // Asynchronous reset in the middle of a WAIT.
        drive_op(CLS_LD, 24'h123456, 48'h800, 3'b111);
        @(negedge clk);
        @(negedge clk);
        chk_eq("pre_rst_req", mem_if.ow_mem_req, 1);
        #2 iw_rst = 1'b0;
        #1;
        chk_eq("midrst_req", mem_if.ow_mem_req, 0);
        chk_eq("midrst_stall", ow_stall, 0);
        chk_eq("midrst_out", {ow_result, we3, ow_pc}, 0);
        drive_nop();
        @(negedge clk);
        iw_rst = 1'b1;
        m_we = 3'b000; m_res = 24'h0; m_res_ok = 1'b1;

        // Randomized mix.
        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                run_alu(24'($urandom), 3'($urandom), $urandom_range(0, 3) == 0 ? 2 : 0,
                        $urandom_range(0, 7) == 0);
            end else begin
                d  = $urandom_range(1, TMO + 2);
                fa = ($urandom_range(0, 3) == 0) ? $urandom_range(1, (d < TMO) ? d : TMO) : 0;
                run_mem(kind == 2, {16'($urandom), 32'($urandom)}, 24'($urandom), 24'($urandom),
                        d, $urandom_range(0, 2) == 0, $urandom_range(1, 3), fa);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
